// File: rtl/sdft_bin_scheduler_if.sv
// Signal bundle between the SDFT bin scheduler and its sample source,
// bin memory, twiddle ROM and update engine.
interface sdft_bin_scheduler_if #(
  parameter int unsigned AW = 4
);
  localparam int unsigned DW = 24;

  logic          sample_valid;
  logic [DW-1:0] delta;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] bin_addr;
  logic [DW-1:0] rd_real;
  logic [DW-1:0] rd_imag;
  logic [DW-1:0] tw_real;
  logic [DW-1:0] tw_imag;
  logic [DW-1:0] op_real;
  logic [DW-1:0] op_imag;
  logic [DW-1:0] op_delta;
  logic [DW-1:0] op_tw_real;
  logic [DW-1:0] op_tw_imag;
  logic          eng_en;
  logic          eng_done;
  logic [DW-1:0] eng_out;
  logic          wr_en;
  logic [DW-1:0] wr_data;

  modport master (
    input  sample_valid, delta, rd_real, rd_imag, tw_real, tw_imag, eng_done, eng_out,
    output busy, frame_done, overrun, err, rd_en, bin_addr,
           op_real, op_imag, op_delta, op_tw_real, op_tw_imag, eng_en, wr_en, wr_data
  );

  modport slave (
    output sample_valid, delta, rd_real, rd_imag, tw_real, tw_imag, eng_done, eng_out,
    input  busy, frame_done, overrun, err, rd_en, bin_addr,
           op_real, op_imag, op_delta, op_tw_real, op_tw_imag, eng_en, wr_en, wr_data
  );
endinterface

// File: rtl/sdft_bin_scheduler.sv
// Sequences one sliding-DFT update per bin for each accepted sample:
// read bin and twiddle, issue to the engine, wait for its result, write back.
module sdft_bin_scheduler #(
  parameter int unsigned NBINS   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  sdft_bin_scheduler_if.master bus
);
  localparam int unsigned   DW       = 24;
  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_BIN = AW'(NBINS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] delta_q;
  logic [CW-1:0] to_cnt;

  logic          timeout;
  logic          last_bin;
  logic          busy_d;
  logic          rd_en_d;
  logic          eng_en_d;
  logic          wr_en_d;
  logic          frame_done_d;
  logic          overrun_d;
  logic          err_d;
  logic [AW-1:0] bin_addr_d;
  logic [CW-1:0] to_cnt_d;
  logic [DW-1:0] delta_d;
  logic [DW-1:0] wr_data_d;

  // Timeout fires on the last permitted WAIT cycle only if the engine stays silent.
  assign timeout  = (state == S_WAIT) && !bus.eng_done && (to_cnt == TO_LAST);
  assign last_bin = (bus.bin_addr == LAST_BIN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.sample_valid) state_n = S_READ;
      S_READ:  state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done)  state_n = S_WRITE;
        else if (timeout)  state_n = last_bin ? S_DONE : S_READ;
      end
      S_WRITE: state_n = last_bin ? S_DONE : S_READ;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes line up with the state they belong to.
  always_comb begin
    busy_d       = (state_n != S_IDLE);
    rd_en_d      = (state_n == S_READ);
    eng_en_d     = (state == S_ISSUE);
    wr_en_d      = (state_n == S_WRITE);
    frame_done_d = (state_n == S_DONE);
    overrun_d    = bus.sample_valid && (state != S_IDLE) && !bus.overrun;
    err_d        = bus.err || timeout;
    bin_addr_d   = bus.bin_addr;
    to_cnt_d     = to_cnt;
    delta_d      = delta_q;
    wr_data_d    = bus.wr_data;

    if (state == S_IDLE || state == S_DONE) bin_addr_d = '0;
    else if (state_n == S_READ)             bin_addr_d = bus.bin_addr + AW'(1);

    if (state == S_ISSUE)                      to_cnt_d = '0;
    else if (state == S_WAIT && !bus.eng_done) to_cnt_d = to_cnt + CW'(1);

    if (state == S_IDLE && bus.sample_valid) delta_d = bus.delta;
    if (state == S_WAIT && bus.eng_done)     wr_data_d = bus.eng_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy       <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.eng_en     <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.err        <= 1'b0;
      bus.bin_addr   <= '0;
      bus.wr_data    <= '0;
      bus.op_real    <= '0;
      bus.op_imag    <= '0;
      bus.op_delta   <= '0;
      bus.op_tw_real <= '0;
      bus.op_tw_imag <= '0;
      to_cnt         <= '0;
      delta_q        <= '0;
    end else begin
      bus.busy       <= busy_d;
      bus.rd_en      <= rd_en_d;
      bus.eng_en     <= eng_en_d;
      bus.wr_en      <= wr_en_d;
      bus.frame_done <= frame_done_d;
      bus.overrun    <= overrun_d;
      bus.err        <= err_d;
      bus.bin_addr   <= bin_addr_d;
      bus.wr_data    <= wr_data_d;
      to_cnt         <= to_cnt_d;
      delta_q        <= delta_d;
      if (state == S_ISSUE) begin
        bus.op_real    <= bus.rd_real;
        bus.op_imag    <= bus.rd_imag;
        bus.op_delta   <= delta_q;
        bus.op_tw_real <= bus.tw_real;
        bus.op_tw_imag <= bus.tw_imag;
      end
    end
  end
endmodule

// File: tb/tb_sdft_bin_scheduler.sv
// Bench for sdft_bin_scheduler: memory/engine models driven at negedge,
// transaction-level expectations (issue order, writes, frame latency).
module tb_sdft_bin_scheduler;
  localparam int unsigned NB  = 4;
  localparam int unsigned AWT = 2;
  localparam int unsigned TO  = 8;
  localparam int unsigned DW  = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdft_bin_scheduler_if #(.AW(AWT)) bus ();
  sdft_bin_scheduler #(.NBINS(NB), .AW(AWT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [DW-1:0] mem_re[NB];
  logic [DW-1:0] mem_im[NB];
  logic [DW-1:0] twr[NB];
  logic [DW-1:0] twi[NB];
  logic [DW-1:0] stub_val[NB];
  int            stub_lat[NB];   // WAIT cycles incl. done; 0 = engine never answers

  int            issue_idx = 0;
  int            n_wr = 0;
  int            n_ovr = 0;
  int            t_done = -1;
  int            stray = 0;
  int            pulse_viol = 0;
  bit            in_frame = 0;
  bit            exp_err = 0;
  logic [DW-1:0] exp_delta = '0;
  int            q_bin[$];
  logic [DW-1:0] q_val[$];
  logic [4:0]    prev_pulse = '0;
  bit            rd_pend = 0;
  logic [AWT-1:0] rd_addr = '0;
  logic [AWT-1:0] cur_bin = '0;
  int            pend = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic monitor();
    logic [4:0]     pulse;
    logic [AWT-1:0] ib;
    pulse = {bus.eng_en, bus.rd_en, bus.wr_en, bus.frame_done, bus.overrun};
    if ((pulse & prev_pulse) != 5'd0) pulse_viol++;
    prev_pulse = pulse;
    if (bus.overrun) n_ovr++;
    if (bus.eng_en) begin
      if (!in_frame || issue_idx >= int'(NB)) stray++;
      else begin
        ib = AWT'(issue_idx);
        chk("issue_bin",  32'(bus.bin_addr),   32'(ib));
        chk("op_real",    32'(bus.op_real),    32'(mem_re[ib]));
        chk("op_imag",    32'(bus.op_imag),    32'(mem_im[ib]));
        chk("op_tw_real", 32'(bus.op_tw_real), 32'(twr[ib]));
        chk("op_tw_imag", 32'(bus.op_tw_imag), 32'(twi[ib]));
        chk("op_delta",   32'(bus.op_delta),   32'(exp_delta));
      end
      issue_idx++;
    end
    if (bus.wr_en) begin
      n_wr++;
      if (q_bin.size() == 0) stray++;
      else begin
        chk("wr_bin",  32'(bus.bin_addr), 32'(q_bin.pop_front()));
        chk("wr_data", 32'(bus.wr_data),  32'(q_val.pop_front()));
      end
    end
    if (bus.frame_done) begin
      if (in_frame) begin t_done = cyc; in_frame = 0; end
      else stray++;
    end
  endtask

  // Memory/ROM with one-cycle read latency plus a delay-programmable engine stub.
  task automatic env();
    bus.sample_valid = 1'b0;
    bus.eng_done     = 1'b0;
    bus.eng_out      = DW'($urandom);
    if (rd_pend) begin
      bus.rd_real = mem_re[rd_addr];
      bus.rd_imag = mem_im[rd_addr];
      bus.tw_real = twr[rd_addr];
      bus.tw_imag = twi[rd_addr];
    end else begin
      bus.rd_real = DW'($urandom);
      bus.rd_imag = DW'($urandom);
      bus.tw_real = DW'($urandom);
      bus.tw_imag = DW'($urandom);
    end
    rd_pend = (bus.rd_en === 1'b1);
    rd_addr = bus.bin_addr;
    if (bus.eng_en === 1'b1) begin
      cur_bin = AWT'(issue_idx - 1);
      pend    = stub_lat[cur_bin];
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.eng_done = 1'b1;
        bus.eng_out  = stub_val[cur_bin];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
    env();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_overrun"},    32'(bus.overrun),    32'd0);
    chk({tag, "_err"},        32'(bus.err),        32'd0);
    chk({tag, "_rd_en"},      32'(bus.rd_en),      32'd0);
    chk({tag, "_bin_addr"},   32'(bus.bin_addr),   32'd0);
    chk({tag, "_eng_en"},     32'(bus.eng_en),     32'd0);
    chk({tag, "_wr_en"},      32'(bus.wr_en),      32'd0);
    chk({tag, "_wr_data"},    32'(bus.wr_data),    32'd0);
    chk({tag, "_ops"}, 32'(bus.op_real | bus.op_imag | bus.op_delta | bus.op_tw_real | bus.op_tw_imag), 32'd0);
  endtask

  task automatic randomize_mem();
    for (int b = 0; b < int'(NB); b++) begin
      mem_re[b] = DW'($urandom);
      mem_im[b] = DW'($urandom);
      twr[b]    = DW'($urandom);
      twi[b]    = DW'($urandom);
    end
  endtask

  task automatic set_stub(input int lat);
    for (int b = 0; b < int'(NB); b++) begin
      stub_lat[b] = lat;
      stub_val[b] = DW'(24'h100 + b);
    end
  endtask

  // One frame: expected latency = sum of per-bin costs (3+L, or 2+TIMEOUT when silent) + DONE.
  task automatic run_frame(input logic [DW-1:0] d, input int ovr_at, input bit sv_in_done,
                           input bit done_in_read, input string tag);
    int exp_lat;
    int nexp;
    int t0;
    int budget;
    int exp_ovr;
    exp_lat = 1;
    nexp    = 0;
    q_bin.delete();
    q_val.delete();
    for (int b = 0; b < int'(NB); b++) begin
      if (stub_lat[b] == 0) begin
        exp_lat += 2 + int'(TO);
        exp_err  = 1'b1;
      end else begin
        exp_lat += 3 + stub_lat[b];
        q_bin.push_back(b);
        q_val.push_back(stub_val[b]);
        nexp++;
      end
    end
    exp_ovr   = (ovr_at > 0 ? 1 : 0) + (sv_in_done ? 1 : 0);
    issue_idx = 0;
    n_wr      = 0;
    n_ovr     = 0;
    t_done    = -1;
    exp_delta = d;
    in_frame  = 1'b1;
    bus.sample_valid = 1'b1;
    bus.delta        = d;
    step();
    t0 = cyc;
    chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    chk({tag, "_bin0"},      32'(bus.bin_addr), 32'd0);
    if (done_in_read) begin
      bus.eng_done = 1'b1;
      bus.eng_out  = 24'hBADBAD;
    end
    budget = 0;
    while (t_done < 0 && budget < 400) begin
      if (ovr_at > 0 && cyc - t0 == ovr_at) begin
        bus.sample_valid = 1'b1;
        bus.delta        = 24'h7FFFFF;
        step();
        chk({tag, "_ovr_pulse"}, 32'(bus.overrun), 32'd1);
      end else begin
        step();
      end
      budget++;
    end
    chk({tag, "_done_seen"}, 32'(t_done >= 0), 32'd1);
    chk({tag, "_latency"},   32'(t_done - t0 + 1), 32'(exp_lat));
    in_frame = 1'b0;
    if (sv_in_done) begin
      bus.sample_valid = 1'b1;
      bus.delta        = DW'($urandom);
    end
    step();
    chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    chk({tag, "_bin_rst"},   32'(bus.bin_addr), 32'd0);
    step();
    chk({tag, "_no_restart"}, 32'(bus.busy), 32'd0);
    chk({tag, "_n_wr"},       32'(n_wr), 32'(nexp));
    chk({tag, "_n_ovr"},      32'(n_ovr), 32'(exp_ovr));
    chk({tag, "_err"},        32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    randomize_mem();
    set_stub(3);
    bus.delta = '0;
    env();
    bus.sample_valid = 1'b1;
    bus.delta        = 24'h123456;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    chk("post_reset_idle", 32'(bus.busy), 32'd0);

    // Nominal frame: engine answers on the third WAIT cycle, data 0x100+bin.
    run_frame(24'h000010, 0, 1'b0, 1'b0, "nom");

    // Done exactly on the last permitted WAIT cycle still writes.
    randomize_mem();
    set_stub(3);
    stub_lat[1] = int'(TO);
    run_frame(DW'($urandom), 0, 1'b0, 1'b0, "bound");

    // Engine silent for bin 2: no write there, err sets, frame still completes.
    set_stub(3);
    stub_lat[2] = 0;
    run_frame(DW'($urandom), 0, 1'b0, 1'b0, "tmo");

    // Overrun mid-frame and in DONE; err stays sticky.
    set_stub(3);
    run_frame(24'h000010, 5, 1'b1, 1'b0, "ovr");

    // Reset during WAIT of bin 1, with a sample offered during reset.
    set_stub(3);
    issue_idx = 0;
    exp_delta = 24'h0000AA;
    in_frame  = 1'b1;
    q_bin.delete();
    q_val.delete();
    bus.sample_valid = 1'b1;
    bus.delta        = 24'h0000AA;
    step();
    budget = 0;
    while (issue_idx < 2 && budget < 100) begin step(); budget++; end
    chk("mid_reset_reached", 32'(issue_idx), 32'd2);
    rst = 1'b1;
    in_frame = 1'b0;
    bus.sample_valid = 1'b1;
    stray = 0;
    step();
    check_zero("mid_reset");
    rst = 1'b0;
    exp_err = 1'b0;
    repeat (10) step();
    chk("mid_reset_quiet", 32'(stray), 32'd0);
    chk("mid_reset_idle",  32'(bus.busy), 32'd0);
    run_frame(DW'($urandom), 0, 1'b0, 1'b0, "after_rst");

    // Stray engine done in IDLE and in READ.
    bus.eng_done = 1'b1;
    bus.eng_out  = 24'hDEAD00;
    step();
    chk("stray_idle_busy", 32'(bus.busy), 32'd0);
    chk("stray_idle_wr",   32'(bus.wr_en), 32'd0);
    run_frame(DW'($urandom), 0, 1'b0, 1'b1, "stray_read");

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      randomize_mem();
      for (int b = 0; b < int'(NB); b++) begin
        stub_lat[b] = int'($urandom_range(0, TO));
        stub_val[b] = DW'($urandom);
      end
      run_frame(DW'($urandom), 0, 1'b0, 1'b0, "rand");
    end

    chk("pulse_width", 32'(pulse_viol), 32'd0);
    chk("stray_events", 32'(stray), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sdft_bin_scheduler.md
SDFT_BIN_SCHEDULER -- requirements
Module: sdft_bin_scheduler

Interface
REQ-001 The block SHALL have parameter NBINS, default 16, giving the number of frequency bins updated per sample (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default 4, giving the bin address width (log2 NBINS).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for engine done.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock, one clock domain; all logic on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- sample_valid  in  1  one-cycle pulse; new delta (x[n]-x[n-N]) available.
- delta  in  24  sample difference, captured on accepted sample_valid.
- busy  out  1  high from accept through the DONE state.
- frame_done  out  1  one-cycle pulse; all NBINS bins written.
- overrun  out  1  one-cycle pulse; sample_valid dropped.
- err  out  1  sticky engine-timeout flag.
- rd_en  out  1  bin/twiddle memory read strobe.
- bin_addr  out  AW  bin index for memory read/write and twiddle ROM.
- rd_real, rd_imag  in  24 each  bin memory data, valid 1 cycle after rd_en.
- tw_real, tw_imag  in  24 each  twiddle ROM data, valid 1 cycle after rd_en.
- op_real, op_imag, op_delta, op_tw_real, op_tw_imag  out  24 each  registered engine operands.
- eng_en  out  1  one-cycle engine start pulse.
- eng_done  in  1  engine completion pulse.
- eng_out  in  24  engine result, valid with eng_done.
- wr_en  out  1  one-cycle bin write strobe.
- wr_data  out  24  result written to bin_addr.

Function
REQ-005 The block SHALL implement the states IDLE, READ, ISSUE, WAIT, WRITE and DONE.
REQ-006 In IDLE, a sample_valid pulse SHALL latch delta, set bin_addr=0, and move to READ on the next cycle; busy SHALL be high from that cycle.
REQ-007 The READ state SHALL last one cycle with rd_en=1, and then move to ISSUE.
REQ-008 ISSUE SHALL last one cycle:
- capture rd_real/rd_imag/tw_real/tw_imag and the latched delta into the op_* registers;
- drive eng_en=1;
- clear the timeout counter;
- move to WAIT.
REQ-009 In WAIT, eng_done=1 SHALL latch eng_out into wr_data and move to WRITE.
REQ-010 In WAIT, the counter SHALL increment each cycle without done; when the count reaches TIMEOUT, the block SHALL set err=1, skip the write, and advance as REQ-012.
REQ-011 WRITE SHALL last one cycle with wr_en=1 at the current bin_addr.
REQ-012 After WRITE or a timeout, if bin_addr==NBINS-1 the block SHALL go to DONE; otherwise it SHALL increment bin_addr and go to READ.
REQ-013 bin_addr SHALL never wrap within a frame.
REQ-014 DONE SHALL last one cycle with frame_done=1, and then return to IDLE with busy=0 and bin_addr=0.
REQ-015 Per-bin cycle count SHALL be 3+L, where L is the number of WAIT cycles including the done cycle.
REQ-016 Frame latency from the sample_valid edge to frame_done SHALL be NBINS*(3+L)+1 cycles.
REQ-017 sample_valid while busy=1, including in the DONE state, SHALL pulse overrun for one cycle, leave the latched delta unchanged, and not restart the frame.
REQ-018 eng_done outside WAIT SHALL be ignored.
REQ-019 eng_done in the same cycle as the timeout count being reached SHALL be treated as done: no err, and the write SHALL proceed.
REQ-020 eng_en, rd_en, wr_en, frame_done and overrun SHALL each be high for at most one consecutive cycle.
REQ-021 err SHALL clear only on rst.
REQ-022 All arithmetic is in the engine; the block SHALL pass the 24-bit values unmodified.

Reset
REQ-023 When rst=1 at a clock edge, the state SHALL become IDLE and every output SHALL reset to 0: busy, frame_done, overrun, err, rd_en, bin_addr, op_*, eng_en, wr_en and wr_data.
REQ-024 The latched delta and the timeout counter SHALL clear to 0 on reset.
REQ-025 Reset mid-frame SHALL abandon the frame with no further wr_en or frame_done.
REQ-026 sample_valid during rst SHALL be ignored.
REQ-027 The first sample_valid after rst falls SHALL be accepted normally.

Verification
REQ-028 Nominal: NBINS=4, engine stub returns done 3 cycles after eng_en with eng_out=0x100+bin, sample_valid with delta=0x000010 -> wr_en at bins 0,1,2,3 with data 0x100..0x103, op_delta=0x000010 on each, and frame_done 25 cycles after the sample edge.
REQ-029 Overrun: sample_valid at cycle 5 of a frame with delta=0x7FFFFF -> one overrun pulse; op_delta stays 0x000010; exactly 4 writes.
REQ-030 Timeout: TIMEOUT=8, stub never answers for bin 2 -> err=1 after 8 WAIT cycles; no wr_en for bin 2; bin 3 is processed; frame_done still occurs.
REQ-031 Boundary: eng_done on the 8th WAIT cycle with TIMEOUT=8 -> write occurs and err stays 0.
REQ-032 Reset mid-frame: rst asserted during WAIT of bin 1 -> next cycle all outputs are 0; no frame_done; a new sample then completes a full 4-bin frame.
REQ-033 Stray done: eng_done pulsed in IDLE and READ -> no wr_en and no state change.
